// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encoding and constants for the framing UART transmitter
package uart_frame_pkg;

  localparam logic [7:0] DEFAULT_SOF = 8'hAA;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_SOF  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
`ifdef UART_FRAME_CHKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_DONE = 3'd5
  } state_e;

  function automatic int unsigned buf_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload register file, synchronous write and asynchronous read
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - buffers one payload frame and writes SOF, LEN, payload to a UART TX FIFO
// Define UART_FRAME_CHKSUM_EN to append the mod-256 checksum of LEN and payload.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SOF     = DEFAULT_SOF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       frame_done,
  output logic       ovf
);

  localparam int unsigned AW        = buf_addr_w(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic       trunc_q, trunc_d;
  logic       buf_we;
  logic [7:0] rd_data;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      trunc_q <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      trunc_q <= trunc_d;
`ifdef UART_FRAME_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    trunc_d    = trunc_q;
`ifdef UART_FRAME_CHKSUM_EN
    chk_d      = chk_q;
`endif
    in_ready   = 1'b0;
    wr_uart    = 1'b0;
    w_data     = 8'h00;
    busy       = 1'b0;
    frame_done = 1'b0;
    ovf        = 1'b0;
    buf_we     = 1'b0;

    // Outputs are held quiet while rst is high so a mid-frame reset cannot leak a write.
    if (!rst) begin
      busy = (state_q != ST_FILL) || (cnt_q != 8'd0);
      case (state_q)
        ST_FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (cnt_q < MAX_LEN_B) begin
              buf_we = 1'b1;
              cnt_d  = cnt_q + 8'd1;
            end else begin
              trunc_d = 1'b1;
            end
            if (in_last) begin
              state_d = ST_SOF;
            end
          end
        end
        ST_SOF: begin
          w_data  = SOF;
          wr_uart = !tx_full;
          if (wr_uart) begin
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          w_data  = cnt_q;
          wr_uart = !tx_full;
          if (wr_uart) begin
`ifdef UART_FRAME_CHKSUM_EN
            chk_d = cnt_q;
`endif
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          w_data  = rd_data;
          wr_uart = !tx_full;
          if (wr_uart) begin
`ifdef UART_FRAME_CHKSUM_EN
            chk_d = chk_q + rd_data;
`endif
            if (idx_q == cnt_q - 8'd1) begin
`ifdef UART_FRAME_CHKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
`endif
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        ST_CHK: begin
          w_data  = chk_q;
          wr_uart = !tx_full;
          if (wr_uart) begin
            state_d = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          frame_done = 1'b1;
          ovf        = trunc_q;
          cnt_d      = 8'd0;
          idx_d      = 8'd0;
          trunc_d    = 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
          chk_d      = 8'd0;
`endif
          state_d    = ST_FILL;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - table-driven scoreboard bench for uart_frame_tx
module tb_uart_frame_tx;

  localparam logic [7:0] SOF_B = 8'hAA;
`ifdef UART_FRAME_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic       frame_done;
  logic       ovf;

  uart_frame_tx #(
    .MAX_LEN (16),
    .SOF     (SOF_B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [19:0][7:0] d;
    int              exp_len;
    logic [7:0]      exp_chk;
    logic            exp_ovf;
    int              stall_idx;
  } vec_t;

  typedef struct packed {
    logic       is_done;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_vec = 0;
  int   n_err = 0;
  int   wr_seen = 0;
  bit   done_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tx_full) check("no_write_while_full", {31'd0, wr_uart}, 32'd0);
    if (wr_uart) begin
      wr_seen++;
      check("in_ready_low_while_emitting", {31'd0, in_ready}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", {24'd0, w_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("write_not_done_event", {31'd0, e.is_done}, 32'd0);
        check("w_data", {24'd0, w_data}, {24'd0, e.data});
      end
    end
    if (frame_done) begin
      done_seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("frame_done_expected", {31'd0, e.is_done}, 32'd1);
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end else begin
      if (ovf) check("ovf_without_done", 32'd1, 32'd0);
    end
  end

  task automatic drive_bytes(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = (i == v.n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int k;
    int stall_cnt;
    bit stalled;
    sb.push_back({1'b0, SOF_B, 1'b0});
    sb.push_back({1'b0, 8'(v.exp_len), 1'b0});
    for (int i = 0; i < v.exp_len; i++) sb.push_back({1'b0, v.d[i], 1'b0});
    if (CHK_BYTES == 1) sb.push_back({1'b0, v.exp_chk, 1'b0});
    sb.push_back({1'b1, 8'h00, v.exp_ovf});
    wr_seen   = 0;
    done_seen = 1'b0;
    drive_bytes(v);
    k = 1;
    stall_cnt = 0;
    stalled = 1'b0;
    while (!done_seen && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) tx_full = 1'b0;
      end else if (v.stall_idx >= 0 && !stalled && wr_seen == 2 + v.stall_idx) begin
        tx_full   = 1'b1;
        stalled   = 1'b1;
        stall_cnt = 5;
      end
    end
    check("frame_cycles", k, v.exp_len + 2 + CHK_BYTES + 2 + (v.stall_idx >= 0 ? 5 : 0));
    check("scoreboard_drained", sb.size(), 0);
    check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int k;

    tbl[0] = '{n: 3, d: '0, exp_len: 3, exp_chk: 8'h09, exp_ovf: 1'b0, stall_idx: -1};
    tbl[0].d[0] = 8'h01; tbl[0].d[1] = 8'h02; tbl[0].d[2] = 8'h03;
    tbl[1] = '{n: 1, d: '0, exp_len: 1, exp_chk: 8'h00, exp_ovf: 1'b0, stall_idx: -1};
    tbl[1].d[0] = 8'hFF;
    tbl[2] = '{n: 20, d: '0, exp_len: 16, exp_chk: 8'h88, exp_ovf: 1'b1, stall_idx: -1};
    for (int i = 0; i < 20; i++) tbl[2].d[i] = 8'(i);
    tbl[3] = tbl[0];
    tbl[3].stall_idx = 1;
    tbl[4] = '{n: 2, d: '0, exp_len: 2, exp_chk: 8'h05, exp_ovf: 1'b0, stall_idx: -1};
    tbl[4].d[0] = 8'h01; tbl[4].d[1] = 8'h02;
    tbl[5] = '{n: 16, d: '0, exp_len: 16, exp_chk: 8'h88, exp_ovf: 1'b0, stall_idx: -1};
    for (int i = 0; i < 16; i++) tbl[5].d[i] = 8'(8'h80 + i);
    tbl[6] = '{n: 17, d: '0, exp_len: 16, exp_chk: 8'h78, exp_ovf: 1'b1, stall_idx: -1};
    for (int i = 0; i < 17; i++) tbl[6].d[i] = 8'(3 * i);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_uart", {31'd0, wr_uart}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int t = 0; t < 7; t++) run_frame(tbl[t]);

    // Reset while the LEN byte is pending: only SOF must have gone out.
    v = tbl[4];
    sb.push_back({1'b0, SOF_B, 1'b0});
    wr_seen   = 0;
    done_seen = 1'b0;
    drive_bytes(v);
    k = 0;
    while (wr_seen < 1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("sof_before_reset", wr_seen, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_wr_uart", {31'd0, wr_uart}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("after_mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_mid_reset_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abandoned_writes", wr_seen, 1);
    check("abandoned_no_done", {31'd0, done_seen}, 32'd0);
    check("abandoned_sb_empty", sb.size(), 0);

    v = '{n: 1, d: '0, exp_len: 1, exp_chk: 8'h06, exp_ovf: 1'b0, stall_idx: -1};
    v.d[0] = 8'h05;
    run_frame(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
